// File: rtl/reg_file_2r1w_if.sv
// Register-file port bundle: one write port, two read ports.
// Optional REGFILE_DEBUG_EN adds a debug read port and a retired-write counter.
interface reg_file_2r1w_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    localparam int unsigned CNT_W = 16;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
`ifdef REGFILE_DEBUG_EN
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [CNT_W-1:0]  reg_wr_count;
`endif

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2
`ifdef REGFILE_DEBUG_EN
        , output dbg_addr
        , input  dbg_data, reg_wr_count
`endif
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2
`ifdef REGFILE_DEBUG_EN
        , input  dbg_addr
        , output dbg_data, reg_wr_count
`endif
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// 32x32 integer register file: sync write, combinational read with write bypass, x0 = 0.
// Define REGFILE_DEBUG_EN for the debug read port and the 16-bit retired-write counter.
module reg_file_2r1w #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic              clk,
    input logic              rst,
    reg_file_2r1w_if.slave   rf
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 16;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_en_c;

    // A write to x0 is architecturally a no-op, so it never counts as a write.
    always_comb wr_en_c = rf.we && (rf.waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en_c) begin
            regs_d[rf.waddr] = rf.wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle bypass lets decode see the value being written back.
    always_comb begin
        rf.rdata1 = '0;
        if (!rst && (rf.raddr1 != '0)) begin
            rf.rdata1 = (wr_en_c && (rf.waddr == rf.raddr1)) ? rf.wdata : regs_q[rf.raddr1];
        end
    end

    always_comb begin
        rf.rdata2 = '0;
        if (!rst && (rf.raddr2 != '0)) begin
            rf.rdata2 = (wr_en_c && (rf.waddr == rf.raddr2)) ? rf.wdata : regs_q[rf.raddr2];
        end
    end

`ifdef REGFILE_DEBUG_EN
    logic [CNT_W-1:0] wr_count_q;
    logic [CNT_W-1:0] wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_en_c) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    // Debug view shows stored state only, never the in-flight write.
    always_comb begin
        rf.dbg_data = '0;
        if (!rst && (rf.dbg_addr != '0)) begin
            rf.dbg_data = regs_q[rf.dbg_addr];
        end
    end

    always_comb rf.reg_wr_count = wr_count_q;
`endif
endmodule
